// File: rtl/rstmgr_seq.sv
// Reset sequencer: stretched, staggered release of NUM_DOMAINS active-low resets plus per-domain software reset.
// Optional sticky reset-cause register enabled by defining RSTMGR_SEQ_CAUSE_EN.
module rstmgr_seq #(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned STAGGER_CYCLES = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ndmreset_i,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] domain_rst_no,
  output logic                   rst_done_o,
  output logic [NUM_DOMAINS-1:0] busy_o
`ifdef RSTMGR_SEQ_CAUSE_EN
  ,
  input  logic                   cause_clr_i,
  output logic [2:0]             rst_cause_o
`endif
);

  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] scnt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] swcnt [NUM_DOMAINS];

  // Sequencer: stretch in ASSERT, staggered release in RELEASE, software resets in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_ASSERT;
      cnt           <= STRETCH_LOAD;
      scnt          <= STAGGER_LOAD;
      idx           <= IDX_W'(1);
      domain_rst_no <= '0;
      rst_done_o    <= 1'b0;
      busy_o        <= '0;
      for (int unsigned k = 0; k < NUM_DOMAINS; k++) swcnt[k] <= '0;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (ndmreset_i) begin
            cnt <= STRETCH_LOAD;
          end else if (cnt == '0) begin
            domain_rst_no[0] <= 1'b1;
            idx              <= IDX_W'(1);
            scnt             <= STAGGER_LOAD;
            if (NUM_DOMAINS == 1) begin
              state      <= ST_IDLE;
              rst_done_o <= 1'b1;
            end else begin
              state <= ST_RELEASE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (ndmreset_i) begin
            state         <= ST_ASSERT;
            domain_rst_no <= '0;
            cnt           <= STRETCH_LOAD;
          end else if (scnt == '0) begin
            domain_rst_no[idx] <= 1'b1;
            idx                <= idx + IDX_W'(1);
            scnt               <= STAGGER_LOAD;
            if (idx == LAST_IDX) begin
              state      <= ST_IDLE;
              rst_done_o <= 1'b1;
            end
          end else begin
            scnt <= scnt - CNT_W'(1);
          end
        end

        ST_IDLE: begin
          if (ndmreset_i) begin
            state         <= ST_ASSERT;
            domain_rst_no <= '0;
            rst_done_o    <= 1'b0;
            busy_o        <= '0;
            cnt           <= STRETCH_LOAD;
            for (int unsigned k = 0; k < NUM_DOMAINS; k++) swcnt[k] <= '0;
          end else begin
            // Each domain counts down independently once its request drops.
            for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
              if (sw_rst_req_i[k]) begin
                domain_rst_no[k] <= 1'b0;
                busy_o[k]        <= 1'b1;
                swcnt[k]         <= STRETCH_LOAD;
              end else if (busy_o[k]) begin
                if (swcnt[k] == '0) begin
                  domain_rst_no[k] <= 1'b1;
                  busy_o[k]        <= 1'b0;
                end else begin
                  swcnt[k] <= swcnt[k] - CNT_W'(1);
                end
              end
            end
          end
        end

        default: begin
          state         <= ST_ASSERT;
          domain_rst_no <= '0;
          rst_done_o    <= 1'b0;
          cnt           <= STRETCH_LOAD;
        end
      endcase
    end
  end

`ifdef RSTMGR_SEQ_CAUSE_EN
  logic ndm_set_c;
  logic sw_set_c;

  assign ndm_set_c = ndmreset_i && ((state == ST_IDLE) || (state == ST_RELEASE));
  assign sw_set_c  = (state == ST_IDLE) && !ndmreset_i && (|sw_rst_req_i);

  // Sticky cause bits {SW, NDM, POR}; a set in the same cycle overrides a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rst_cause_o <= 3'b001;
    end else begin
      rst_cause_o <= (cause_clr_i ? 3'b000 : rst_cause_o) | {sw_set_c, ndm_set_c, 1'b0};
    end
  end
`else
  // Default build carries no reset-cause register.
`endif

endmodule

// File: doc/rstmgr_seq.md
Name: rstmgr_seq

Overview:
- Parametrised successor to the SoC reset manager: one sequencer drives NUM_DOMAINS active-low reset outputs.
- Behaviour beyond the current manager:
  - reset stretching;
  - staggered per-domain release, domain 0 (core/xbar) first;
  - per-domain software reset;
  - optional sticky reset-cause capture.
- Sits between the power-on reset, the debug module's ndmreset and the per-subsystem reset inputs (core, xbar, peripherals).

Parameters:
- NUM_DOMAINS, 4, number of reset domains (>=1).
- STRETCH_CYCLES, 16, minimum cycles all domains are held in reset (>=1).
- STAGGER_CYCLES, 4, cycles between release of consecutive domains (>=1).
- CNT_W, 8, counter width; must hold max(STRETCH_CYCLES, STAGGER_CYCLES)-1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  power-on reset, synchronous, active-high.
- ndmreset_i  in  1  non-debug-module reset request from debug module, level.
- sw_rst_req_i  in  NUM_DOMAINS  per-domain software reset request, level.
- domain_rst_no  out  NUM_DOMAINS  per-domain reset, active-low, registered.
- rst_done_o  out  1  high when sequencing is complete (state IDLE).
- busy_o  out  NUM_DOMAINS  per-domain software reset in progress.
- (cause_clr_i, rst_cause_o: present only with RSTMGR_SEQ_CAUSE_EN.)

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk_i, reset port rst_i.
- All outputs are registers. Priority order: rst_i > ndmreset_i > sw_rst_req_i.
- rst_i high at a clock edge:
  - state=ASSERT, cnt=STRETCH_CYCLES-1.
  - domain_rst_no=all 0, rst_done_o=0, busy_o=0, all sw counters=0.
- ASSERT:
  - All domains held low.
  - If ndmreset_i=1, cnt reloads to STRETCH_CYCLES-1, so stretching restarts from request deassertion.
  - Else if cnt==0: next state RELEASE; domain_rst_no[0]<=1; idx<=1; scnt<=STAGGER_CYCLES-1.
  - Else cnt decrements.
- RELEASE:
  - If ndmreset_i=1: back to ASSERT; all domains <=0; cnt<=STRETCH_CYCLES-1.
  - Else if scnt==0: domain_rst_no[idx]<=1; idx++; scnt reloads.
  - Else scnt decrements.
  - On the edge that releases domain NUM_DOMAINS-1: state<=IDLE and rst_done_o<=1.
  - NUM_DOMAINS=1: ASSERT goes directly to IDLE with rst_done_o<=1 on the domain-0 release edge.
- Release timing: domain k goes high exactly STRETCH_CYCLES + k*STAGGER_CYCLES edges after the first edge with rst_i=0, provided ndmreset_i stays low.
- IDLE, ndmreset_i=1:
  - state<=ASSERT, all domains low, rst_done_o<=0.
  - All sw counters and busy_o cleared.
- IDLE, sw_rst_req_i[k]=1 (ndmreset_i=0):
  - domain_rst_no[k]<=0, busy_o[k]<=1, swcnt[k]<=STRETCH_CYCLES-1; counter reloads while the request is held.
  - Once the request is low: swcnt[k] decrements; at swcnt[k]==0, domain_rst_no[k]<=1 and busy_o[k]<=0.
  - Domains are independent and may overlap. rst_done_o stays 1.
- sw_rst_req_i is ignored (not latched) in ASSERT and RELEASE.
- Counters never wrap: reload only, and stop at 0.

Optional Feature:
- Macro RSTMGR_SEQ_CAUSE_EN.
- Defined, adds ports:
  - cause_clr_i (in, 1);
  - rst_cause_o (out, 3; sticky bits {SW, NDM, POR}).
- Cause bit rules:
  - rst_i sets rst_cause_o=3'b001, clearing SW and NDM.
  - IDLE/RELEASE to ASSERT via ndmreset_i sets bit1.
  - An accepted sw request in IDLE sets bit2.
  - cause_clr_i=1 clears all bits; a set in the same cycle wins over clear.
- Undefined: ports and register absent; all other behaviour identical.

Test Plan:
- POR, defaults (16/4/4): rst_i high 3 cycles then low -> domain_rst_no = 4'b0000 until edge 16, then 0001@16, 0011@20, 0111@24, 1111@28; rst_done_o=1 at edge 28.
- ndmreset_i pulse for 5 cycles while in IDLE -> rst_done_o=0 next edge, all domains low; domain 0 releases 16 edges after ndmreset_i falls; cause=3'b011 with macro.
- ndmreset_i asserted at edge 22 during RELEASE (domains 0001/0011 released) -> all domains low at edge 23; full sequence restarts; no domain released early.
- sw_rst_req_i=4'b0100 held 10 cycles in IDLE -> domain 2 low, busy_o[2]=1; released 16 edges after request falls; other domains and rst_done_o stay 1.
- sw_rst_req_i[1] and ndmreset_i rise on the same edge in IDLE -> ndm wins: ASSERT, busy_o=0, cause bit2 not set.
- Macro on: cause_clr_i=1 on the same edge as a sw request acceptance -> rst_cause_o bit2=1, others 0; cause_clr_i alone next cycle -> 3'b000.
